axi4_lite_arbiter_2to1: RTL and testbench

Two-master to one-slave AXI4-Lite arbiter that shares a single register slave, such as the test/control register block, between two requesters, for example the host DMA register master and a local configuration sequencer. It carries exactly one transaction at a time, read or write, from address to response. Masters are served round-robin. The block holds no data storage beyond channel pass-through and the grant state.

---
 rtl/axi4_lite_arbiter_2to1_pkg.sv | 13 +
 rtl/axi4_lite_arbiter_2to1_rr.sv | 15 +
 rtl/axi4_lite_arbiter_2to1.sv | 177 +++++++++++++++++
 tb/tb_axi4_lite_arbiter_2to1.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_arbiter_2to1_pkg.sv
// Shared definitions for the two-master AXI4-Lite arbiter: response codes and FSM encoding.
package axi4_lite_arbiter_2to1_pkg;

    localparam logic [1:0] AXI_RESP_OK     = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi4_lite_arbiter_2to1_rr.sv
// Two-way round-robin pick: a lone requester always wins; on a tie, prio names the winner.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// Shares one AXI4-Lite slave between two masters, one transaction at a time, round-robin.
module axi4_lite_arbiter_2to1
    import axi4_lite_arbiter_2to1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    // Upstream masters, packed two-wide
    input  logic [2*ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic [1:0]                S_AWVALID,
    output logic [1:0]                S_AWREADY,
    input  logic [2*DATA_WIDTH-1:0]   S_WDATA,
    input  logic [2*DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic [1:0]                S_WVALID,
    output logic [1:0]                S_WREADY,
    output logic [3:0]                S_BRESP,
    output logic [1:0]                S_BVALID,
    input  logic [1:0]                S_BREADY,
    input  logic [2*ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic [1:0]                S_ARVALID,
    output logic [1:0]                S_ARREADY,
    output logic [2*DATA_WIDTH-1:0]   S_RDATA,
    output logic [3:0]                S_RRESP,
    output logic [1:0]                S_RVALID,
    input  logic [1:0]                S_RREADY,
    // Downstream slave
    output logic [ADDR_WIDTH-1:0]     M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY,
    output logic [1:0]                GRANT,
    output logic                      BUSY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       prio_q, prio_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       ar_done_q, ar_done_d;
    logic [1:0] arb_gnt;

    rr_arbiter_2 u_rr (
        .req  (S_AWVALID | S_ARVALID),
        .prio (prio_q),
        .gnt  (arb_gnt)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            prio_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ar_done_d = ar_done_q;
        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    grant_d   = arb_gnt;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    // Writes take precedence over reads within the winning master
                    if (arb_gnt[0] ? S_AWVALID[0] : S_AWVALID[1]) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                if (M_AWVALID && M_AWREADY) aw_done_d = 1'b1;
                if (M_WVALID && M_WREADY)   w_done_d  = 1'b1;
                if (M_BVALID && M_BREADY) begin
                    state_d = StIdle;
                    grant_d = 2'b00;
                    prio_d  = ~grant_q[1];
                end
            end
            StRd: begin
                if (M_ARVALID && M_ARREADY) ar_done_d = 1'b1;
                if (M_RVALID && M_RREADY) begin
                    state_d = StIdle;
                    grant_d = 2'b00;
                    prio_d  = ~grant_q[1];
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    // Channel muxes: everything is zero except the owner's path in the active direction.
    always_comb begin
        S_AWREADY = 2'b00;
        S_WREADY  = 2'b00;
        S_BRESP   = 4'b0000;
        S_BVALID  = 2'b00;
        S_ARREADY = 2'b00;
        S_RDATA   = '0;
        S_RRESP   = 4'b0000;
        S_RVALID  = 2'b00;
        M_AWADDR  = '0;
        M_AWVALID = 1'b0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        M_ARADDR  = '0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (grant_q[i] && state_q == StWr) begin
                M_AWADDR     = S_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                M_AWVALID    = S_AWVALID[i] & ~aw_done_q;
                S_AWREADY[i] = M_AWREADY & ~aw_done_q;
                M_WDATA      = S_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                M_WSTRB      = S_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
                M_WVALID     = S_WVALID[i] & ~w_done_q;
                S_WREADY[i]  = M_WREADY & ~w_done_q;
                M_BREADY     = S_BREADY[i];
                S_BVALID[i]  = M_BVALID;
                S_BRESP[i*2 +: 2] = M_BRESP;
            end
            if (grant_q[i] && state_q == StRd) begin
                M_ARADDR     = S_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                M_ARVALID    = S_ARVALID[i] & ~ar_done_q;
                S_ARREADY[i] = M_ARREADY & ~ar_done_q;
                M_RREADY     = S_RREADY[i];
                S_RVALID[i]  = M_RVALID;
                S_RDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_RDATA;
                S_RRESP[i*2 +: 2] = M_RRESP;
            end
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = (state_q != StIdle);

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for the 2:1 AXI4-Lite arbiter with a one-cycle register slave model.
module tb_axi4_lite_arbiter_2to1;
    import axi4_lite_arbiter_2to1_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic ACLK, ARESETN;
    logic [2*AW-1:0]   s_awaddr;
    logic [1:0]        s_awvalid, s_awready;
    logic [2*DW-1:0]   s_wdata;
    logic [2*DW/8-1:0] s_wstrb;
    logic [1:0]        s_wvalid, s_wready;
    logic [3:0]        s_bresp;
    logic [1:0]        s_bvalid, s_bready;
    logic [2*AW-1:0]   s_araddr;
    logic [1:0]        s_arvalid, s_arready;
    logic [2*DW-1:0]   s_rdata;
    logic [3:0]        s_rresp;
    logic [1:0]        s_rvalid, s_rready;
    logic [AW-1:0]     m_awaddr, m_araddr;
    logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DW-1:0]     m_wdata, m_rdata;
    logic [DW/8-1:0]   m_wstrb;
    logic [1:0]        m_bresp, m_rresp;
    logic [1:0]        grant;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    axi4_lite_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWADDR(s_awaddr), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
        .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .S_ARADDR(s_araddr), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RVALID(s_rvalid), .S_RREADY(s_rready),
        .M_AWADDR(m_awaddr), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
        .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .M_ARADDR(m_araddr), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
        .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RVALID(m_rvalid), .M_RREADY(m_rready),
        .GRANT(grant), .BUSY(busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Register slave model: word-indexed by addr[3:0], address 15 answers SLVERR on writes.
    logic          slv_awready, slv_wready;
    logic [DW-1:0] mem [16];
    logic          aw_have, w_have, aw_hs_m, w_hs_m;
    logic [AW-1:0] aw_addr_q, wa;
    logic [DW-1:0] w_data_q, wd;

    assign m_awready = slv_awready;
    assign m_wready  = slv_wready;
    assign m_arready = 1'b1;
    assign aw_hs_m   = m_awvalid & m_awready;
    assign w_hs_m    = m_wvalid & m_wready;
    assign wa        = aw_hs_m ? m_awaddr : aw_addr_q;
    assign wd        = w_hs_m ? m_wdata : w_data_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_have   <= 1'b0;
            w_have    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            m_bvalid  <= 1'b0;
            m_bresp   <= 2'b00;
            m_rvalid  <= 1'b0;
            m_rdata   <= '0;
            m_rresp   <= 2'b00;
            for (int i = 0; i < 16; i++) mem[i] <= (i == 4) ? 32'h0000_7704 : 32'h0;
        end else begin
            if ((aw_hs_m || aw_have) && (w_hs_m || w_have) && !m_bvalid) begin
                mem[wa[3:0]] <= wd;
                m_bvalid     <= 1'b1;
                m_bresp      <= (wa[3:0] == 4'hF) ? AXI_RESP_SLVERR : AXI_RESP_OK;
                aw_have      <= 1'b0;
                w_have       <= 1'b0;
            end else begin
                if (aw_hs_m) begin
                    aw_have   <= 1'b1;
                    aw_addr_q <= m_awaddr;
                end
                if (w_hs_m) begin
                    w_have   <= 1'b1;
                    w_data_q <= m_wdata;
                end
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && m_arready && !m_rvalid) begin
                m_rvalid <= 1'b1;
                m_rdata  <= mem[m_araddr[3:0]];
                m_rresp  <= AXI_RESP_OK;
            end else if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic reset_dut();
        ARESETN = 1'b0;
        tick();
        tick();
        ARESETN = 1'b1;
    endtask

    task automatic do_read(input int m, input logic [31:0] addr, output logic [31:0] data);
        bit   done;
        logic ar_hs;
        done = 0;
        data = '0;
        s_araddr[m*32 +: 32] = addr;
        s_arvalid[m] = 1'b1;
        s_rready[m]  = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (s_rvalid[m]) begin
                data = s_rdata[m*32 +: 32];
                done = 1;
            end
            ar_hs = s_arvalid[m] & s_arready[m];
            tick();
            if (ar_hs) s_arvalid[m] = 1'b0;
        end
        s_arvalid[m] = 1'b0;
        if (!done) check("rd_timeout", 64'(done), 64'd1);
    endtask

    logic [31:0] rd;
    int          issued[2], got[2];
    logic [1:0]  prev_g, ar_hs2, aw_hs2, w_hs2;
    logic [1:0]  order[$];
    logic [31:0] t3_exp[2];
    bit          got_b;

    initial begin
        slv_awready = 1'b1;
        slv_wready  = 1'b1;
        s_awaddr = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '1; s_wvalid = '0;
        s_bready = 2'b11; s_araddr = '0; s_arvalid = '0; s_rready = 2'b11;
        reset_dut();

        // Reset state and single read by master 0
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sready", 64'({s_awready, s_wready, s_arready}), 64'd0);
        check("rst_mvalid", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'd0);
        s_araddr[31:0] = 32'h4;
        s_arvalid = 2'b01;
        #1;
        check("t1_arb_grant", 64'(grant), 64'd0);
        check("t1_arb_marvalid", 64'(m_arvalid), 64'd0);
        tick(); #1;
        check("t1_grant", 64'(grant), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_maraddr", 64'(m_araddr), 64'h4);
        check("t1_sarready", 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 2'b00;
        #1;
        check("t1_srvalid", 64'(s_rvalid), 64'd1);
        check("t1_srdata", s_rdata, 64'h0000_0000_0000_7704);
        check("t1_srresp", 64'(s_rresp), 64'd0);
        check("t1_sarready_after", 64'(s_arready), 64'd0);
        tick(); #1;
        check("t1_idle_grant", 64'(grant), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Simultaneous writes right after reset: master 0 first, then master 1
        reset_dut();
        s_awaddr  = {32'h1, 32'h0};
        s_wdata   = {32'h5A5A_5A5A, 32'hA5A5_A5A5};
        s_awvalid = 2'b11;
        s_wvalid  = 2'b11;
        tick(); #1;
        check("t2_grant0", 64'(grant), 64'd1);
        check("t2_mawaddr0", 64'(m_awaddr), 64'h0);
        check("t2_mwdata0", 64'(m_wdata), 64'hA5A5_A5A5);
        check("t2_sready0", 64'({s_awready, s_wready}), 64'b0101);
        tick();
        s_awvalid[0] = 1'b0;
        s_wvalid[0]  = 1'b0;
        #1;
        check("t2_sbvalid0", 64'(s_bvalid), 64'd1);
        tick(); #1;
        check("t2_gap_grant", 64'(grant), 64'd0);
        check("t2_gap_busy", 64'(busy), 64'd0);
        tick(); #1;
        check("t2_grant1", 64'(grant), 64'd2);
        check("t2_mawaddr1", 64'(m_awaddr), 64'h1);
        check("t2_mwdata1", 64'(m_wdata), 64'h5A5A_5A5A);
        tick();
        s_awvalid[1] = 1'b0;
        s_wvalid[1]  = 1'b0;
        #1;
        check("t2_sbvalid1", 64'(s_bvalid), 64'd2);
        tick(); #1;
        check("t2_end_grant", 64'(grant), 64'd0);
        do_read(0, 32'h0, rd);
        check("t2_readback0", 64'(rd), 64'hA5A5_A5A5);
        do_read(1, 32'h1, rd);
        check("t2_readback1", 64'(rd), 64'h5A5A_5A5A);

        // Fairness: four back-to-back reads from each master
        issued = '{0, 0};
        got    = '{0, 0};
        t3_exp = '{32'hA5A5_A5A5, 32'h5A5A_5A5A};
        s_araddr = {32'h1, 32'h0};
        prev_g = 2'b00;
        for (int c = 0; c < 80 && (got[0] + got[1]) < 8; c++) begin
            s_arvalid[0] = (issued[0] < 4);
            s_arvalid[1] = (issued[1] < 4);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (s_arvalid[i] && s_arready[i]) issued[i]++;
                if (s_rvalid[i] && s_rready[i]) begin
                    got[i]++;
                    check("t3_rdata", 64'(s_rdata[i*32 +: 32]), 64'(t3_exp[i]));
                end
            end
            if (grant != 2'b00 && prev_g == 2'b00) order.push_back(grant);
            prev_g = grant;
            tick();
        end
        s_arvalid = 2'b00;
        check("t3_ngrants", 64'(order.size()), 64'd8);
        for (int k = 0; k < order.size() && k < 8; k++) begin
            check("t3_order", 64'(order[k]), (k % 2 == 1) ? 64'd2 : 64'd1);
        end
        tick(); #1;

        // W ahead of AW from master 1, with AW stalled downstream after the grant
        slv_awready = 1'b0;
        s_awaddr[63:32] = 32'hF;
        s_wdata[63:32]  = 32'h1234_5678;
        s_wvalid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_wonly_grant", 64'(grant), 64'd0);
            check("t4_wonly_swready", 64'(s_wready), 64'd0);
            tick();
        end
        s_awvalid = 2'b10;
        tick(); #1;
        check("t4_grant", 64'(grant), 64'd2);
        check("t4_mwvalid", 64'(m_wvalid), 64'd1);
        check("t4_swready", 64'(s_wready), 64'd2);
        check("t4_sawready_stall", 64'(s_awready), 64'd0);
        tick(); #1;
        check("t4_mwvalid_gated", 64'(m_wvalid), 64'd0);
        check("t4_swready_gated", 64'(s_wready), 64'd0);
        check("t4_mawvalid", 64'(m_awvalid), 64'd1);
        slv_awready = 1'b1;
        #1;
        check("t4_sawready", 64'(s_awready), 64'd2);
        tick();
        s_awvalid = 2'b00;
        s_wvalid  = 2'b00;
        #1;
        check("t4_sbvalid", 64'(s_bvalid), 64'd2);
        check("t4_sbresp", 64'(s_bresp), 64'b1000);
        tick(); #1;
        check("t4_end_busy", 64'(busy), 64'd0);
        check("t4_end_sbvalid", 64'(s_bvalid), 64'd0);

        // R backpressure from master 0 while master 1 waits with AR
        s_araddr  = {32'h1, 32'h4};
        s_arvalid = 2'b11;
        s_rready  = 2'b10;
        tick(); #1;
        check("t5_grant", 64'(grant), 64'd1);
        check("t5_sarready", 64'(s_arready), 64'd1);
        tick();
        s_arvalid[0] = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("t5_hold_busy", 64'(busy), 64'd1);
            check("t5_hold_grant", 64'(grant), 64'd1);
            check("t5_hold_rdata", 64'(s_rdata[31:0]), 64'h7704);
            check("t5_hold_sarready1", 64'(s_arready[1]), 64'd0);
            tick(); #1;
        end
        s_rready[0] = 1'b1;
        tick(); #1;
        check("t5_idle_grant", 64'(grant), 64'd0);
        check("t5_idle_sarready", 64'(s_arready), 64'd0);
        tick(); #1;
        check("t5_grant1", 64'(grant), 64'd2);
        check("t5_sarready1", 64'(s_arready), 64'd2);
        tick();
        s_arvalid[1] = 1'b0;
        #1;
        check("t5_srdata1", s_rdata, {32'h5A5A_5A5A, 32'h0});
        tick(); #1;
        do_read(0, 32'h4, rd);
        check("t5_read0", 64'(rd), 64'h7704);

        // Reset in the middle of a master-0 write (prio is 1 here)
        slv_wready = 1'b0;
        s_awaddr[31:0] = 32'h2;
        s_wdata[31:0]  = 32'hDEAD_BEEF;
        s_awvalid = 2'b01;
        s_wvalid  = 2'b01;
        tick(); #1;
        check("t6_grant_single", 64'(grant), 64'd1);
        tick();
        s_awvalid[0] = 1'b0;
        #1;
        check("t6_mwvalid_pending", 64'(m_wvalid), 64'd1);
        ARESETN = 1'b0;
        #1;
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_sctl", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 64'd0);
        check("t6_rst_sdata", s_rdata | 64'({s_bresp, s_rresp}), 64'd0);
        check("t6_rst_mctl", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
        check("t6_rst_mdata", {m_awaddr, m_wdata}, 64'd0);
        s_wvalid   = 2'b00;
        slv_wready = 1'b1;
        tick();
        ARESETN = 1'b1;
        s_araddr[31:0]  = 32'h4;
        s_awaddr[63:32] = 32'h3;
        s_wdata[63:32]  = 32'hCAFE_F00D;
        s_arvalid = 2'b01;
        s_awvalid = 2'b10;
        s_wvalid  = 2'b10;
        s_rready  = 2'b11;
        tick(); #1;
        check("t6_prio0_grant", 64'(grant), 64'd1);
        got_b = 0;
        for (int c = 0; c < 20 && !got_b; c++) begin
            #1;
            ar_hs2 = s_arvalid & s_arready;
            aw_hs2 = s_awvalid & s_awready;
            w_hs2  = s_wvalid & s_wready;
            if (s_bvalid[1]) begin
                got_b = 1;
                check("t6_bresp", 64'(s_bresp), 64'd0);
            end
            tick();
            s_arvalid = s_arvalid & ~ar_hs2;
            s_awvalid = s_awvalid & ~aw_hs2;
            s_wvalid  = s_wvalid & ~w_hs2;
        end
        check("t6_b_seen", 64'(got_b), 64'd1);
        s_arvalid = 2'b00;
        s_awvalid = 2'b00;
        s_wvalid  = 2'b00;
        tick();
        do_read(1, 32'h3, rd);
        check("t6_readback", 64'(rd), 64'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
